// File: rtl/otp_part_buf_pkg.sv
// Shared types and elaboration helpers for the OTP partition buffer.
package otp_part_buf_pkg;

    // Load FSM states. All codes are at least Hamming distance 3 apart so that
    // no single bit flip turns one legal state into another. Any code not listed
    // here is treated as ErrorSt by the FSM.
    typedef enum logic [5:0] {
        IdleSt  = 6'b000000,
        ReadSt  = 6'b000111,
        WaitSt  = 6'b111000,
        DoneSt  = 6'b011110,
        ErrorSt = 6'b101101
    } state_e;

    // Number of OTP words needed to fill a partition.
    function automatic int calc_num_words(input int part_size, input int data_width);
        return part_size / data_width;
    endfunction

    // Width of the word index. It is never narrower than one bit.
    function automatic int calc_idx_width(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    // The partition must be a whole, non-zero number of words.
    function automatic bit part_size_ok(input int part_size, input int data_width);
        return (data_width > 0) && (part_size >= data_width) && ((part_size % data_width) == 0);
    endfunction

    // The last word of the partition must still be addressable.
    function automatic bit addr_range_ok(input longint base_addr, input longint num_words,
                                         input int addr_width);
        return (base_addr + num_words - 1) <= ((longint'(1) << addr_width) - 1);
    endfunction

endpackage

// File: rtl/otp_part_buf.sv
// OTP partition buffer: loads a partition word by word from the OTP macro and
// exposes it only after a complete, error-free load.
module otp_part_buf
    import otp_part_buf_pkg::*;
#(
    parameter int DataWidth      = 32,
    parameter     PartInvDefault = 64'h0,
    parameter int AddrWidth      = 11,
    parameter int PartBaseAddr   = 0
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                init_req_i,
    output logic                                init_done_o,
    output logic                                otp_req_o,
    output logic [AddrWidth-1:0]                otp_addr_o,
    input  logic                                otp_gnt_i,
    input  logic                                otp_rvalid_i,
    input  logic [DataWidth-1:0]                otp_rdata_i,
    input  logic                                otp_err_i,
    output logic [$bits(PartInvDefault)-1:0]    part_data_o,
    output logic                                part_valid_o,
    output logic                                error_o
);

    localparam int PartSize = $bits(PartInvDefault);
    localparam int NumWords = calc_num_words(PartSize, DataWidth);
    localparam int IdxWidth = calc_idx_width(NumWords);

    localparam logic [PartSize-1:0]  InvDefault = PartInvDefault;
    localparam logic [IdxWidth-1:0]  LastIdx    = IdxWidth'(NumWords - 1);
    localparam logic [AddrWidth-1:0] BaseAddr   = AddrWidth'(PartBaseAddr);

    if (!part_size_ok(PartSize, DataWidth)) begin : gen_size_check
        $error("otp_part_buf: partition width must be a non-zero multiple of DataWidth");
    end

    if (!addr_range_ok(longint'(PartBaseAddr), longint'(NumWords), AddrWidth)) begin : gen_addr_check
        $error("otp_part_buf: partition exceeds the OTP address range");
    end

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   idx_q, idx_d;
    logic [PartSize-1:0]   buf_q, buf_d;

    // State, word index and buffer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IdleSt;
            idx_q   <= '0;
            buf_q   <= InvDefault;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state logic: walk the partition one word per req/gnt/rvalid round trip.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        case (state_q)
            IdleSt: begin
                if (otp_rvalid_i) begin
                    state_d = ErrorSt;
                end else if (init_req_i) begin
                    idx_d   = '0;
                    state_d = ReadSt;
                end
            end
            ReadSt: begin
                if (otp_rvalid_i) begin
                    state_d = ErrorSt;
                end else if (otp_gnt_i) begin
                    state_d = WaitSt;
                end
            end
            WaitSt: begin
                if (otp_rvalid_i) begin
                    if (otp_err_i) begin
                        state_d = ErrorSt;
                    end else begin
                        for (int w = 0; w < NumWords; w++) begin
                            if (idx_q == IdxWidth'(w)) begin
                                buf_d[w*DataWidth +: DataWidth] = otp_rdata_i;
                            end
                        end
                        if (idx_q == LastIdx) begin
                            state_d = DoneSt;
                        end else begin
                            idx_d   = idx_q + IdxWidth'(1);
                            state_d = ReadSt;
                        end
                    end
                end
            end
            DoneSt: begin
                if (otp_rvalid_i) begin
                    state_d = ErrorSt;
                end
            end
            ErrorSt: begin
                state_d = ErrorSt;
            end
            default: begin
                state_d = ErrorSt;
            end
        endcase
    end

    // Output decode from the registered state only; illegal codes read as errors.
    always_comb begin
        otp_req_o    = 1'b0;
        init_done_o  = 1'b0;
        part_valid_o = 1'b0;
        error_o      = 1'b0;
        case (state_q)
            IdleSt, WaitSt: begin
            end
            ReadSt: begin
                otp_req_o = 1'b1;
            end
            DoneSt: begin
                part_valid_o = 1'b1;
                init_done_o  = 1'b1;
            end
            default: begin
                error_o     = 1'b1;
                init_done_o = 1'b1;
            end
        endcase
    end

    assign otp_addr_o  = BaseAddr + AddrWidth'(idx_q);
    assign part_data_o = part_valid_o ? buf_q : InvDefault;

endmodule

// File: doc/otp_part_buf.md
# otp_part_buf

Parametrised OTP partition buffer for the OTP controller. On request it reads a whole partition from the OTP macro word by word through a req/gnt/rvalid interface and holds the contents in a register buffer. It exposes the buffer only once the partition is completely and cleanly loaded; otherwise it presents the partition's invalid default. It generalises the fixed-width default-only partition constant to arbitrary partition width, word width and base address, and adds a load FSM with error lockout.

## Interface
- DataWidth, 32, OTP macro word width in bits
- PartInvDefault, '0 (width PartSize), value driven on part_data_o whenever the buffer is not valid; PartSize = $bits(PartInvDefault)
- NumWords, PartSize/DataWidth (derived, localparam), number of words read; PartSize % DataWidth != 0 is an elaboration error
- AddrWidth, 11, OTP word address width
- PartBaseAddr, 0, OTP word address of partition word 0
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- init_req_i  in  1  start partition load (level, sampled in IdleSt)
- init_done_o  out  1  load finished, successfully or with error
- otp_req_o  out  1  read request to OTP macro
- otp_addr_o  out  AddrWidth  word address = PartBaseAddr + word index
- otp_gnt_i  in  1  request accepted
- otp_rvalid_i  in  1  read data valid
- otp_rdata_i  in  DataWidth  read data
- otp_err_i  in  1  read error, qualified by otp_rvalid_i
- part_data_o  out  PartSize  partition contents, word 0 in bits [DataWidth-1:0]
- part_valid_o  out  1  part_data_o holds loaded contents
- error_o  out  1  sticky load/protocol error

## Operation
- States: IdleSt, ReadSt, WaitSt, DoneSt, ErrorSt.
- IdleSt: init_req_i=1 -> clear word index, go ReadSt.
- ReadSt: otp_req_o=1, otp_addr_o=PartBaseAddr+idx. otp_gnt_i=1 -> WaitSt.
- WaitSt: otp_req_o=0. otp_rvalid_i=1 with otp_err_i=0 -> store otp_rdata_i into word idx. If idx==NumWords-1 -> DoneSt, else idx+1 -> ReadSt. otp_rvalid_i=1 with otp_err_i=1 -> ErrorSt.
- otp_rvalid_i in IdleSt, ReadSt, DoneSt or ErrorSt is a protocol error -> ErrorSt.
- DoneSt: part_valid_o=1, init_done_o=1. Terminal; further init_req_i is ignored.
- ErrorSt: error_o=1, init_done_o=1, part_valid_o=0. Terminal until reset.
- part_data_o = part_valid_o ? buffer : PartInvDefault. Partially loaded words are never visible.
- Address arithmetic is AddrWidth bits with wrap-around. PartBaseAddr+NumWords-1 > 2^AddrWidth-1 is an elaboration error.
- The word index is $clog2(NumWords) bits, minimum 1.

## Timing
- Reset values: state IdleSt; buffer PartInvDefault; index 0; otp_req_o 0; otp_addr_o PartBaseAddr; init_done_o 0; part_valid_o 0; error_o 0; part_data_o PartInvDefault.
- Reset is asynchronous mid-load; the FSM returns to IdleSt and any in-flight OTP response arriving after reset release is a protocol error.
- otp_req_o is held with a stable otp_addr_o until otp_gnt_i. gnt in the same cycle as req completes the handshake.
- Minimum 2 cycles per word (grant in the request cycle, rvalid the next cycle). Best-case load: 2*NumWords cycles from the first ReadSt cycle.
- part_valid_o and init_done_o rise in the cycle after the last good rvalid. All outputs are registered or decoded from state only.
- Simultaneous otp_rvalid_i with otp_err_i=1 on the last word -> ErrorSt; DoneSt is never entered.

## Structure
- Package otp_part_buf_pkg holds the state enum, with explicit multi-bit encodings of Hamming distance >= 3; any illegal encoding decodes to ErrorSt.
- The package also holds a localparam helper for NumWords and the elaboration checks.
- No sub-module: FSM, index counter and buffer fit in one module.

## Test plan
- DataWidth=8, PartInvDefault=24'hA5A5A5, PartBaseAddr=0x10, no init_req_i -> part_data_o=24'hA5A5A5, part_valid_o=0 indefinitely.
- Same config, immediate gnt, rdata 0x11/0x22/0x33 -> addresses 0x10,0x11,0x12; after 6 cycles part_data_o=24'h332211, part_valid_o=1, init_done_o=1.
- gnt delayed 3 cycles on word 1 -> otp_addr_o held at 0x11 for all 4 req cycles; final data unchanged.
- otp_err_i=1 with rvalid on word 2 -> error_o=1, part_valid_o=0, part_data_o=24'hA5A5A5, init_done_o=1.
- Spurious otp_rvalid_i in IdleSt -> ErrorSt, error_o=1.
- rst_ni pulsed low during WaitSt of word 1 -> all outputs at reset values immediately; a fresh init_req_i completes a clean load.
